// File: rtl/mtm_alu_serial_rx.sv
// mtm_alu_serial_rx: serial command receiver for the ALU.
// Deframes 11-bit serial frames (start, type, 8 data bits MSB first, stop)
// into a packet of DATA_BYTES data frames plus one CTL frame, validates the
// frame count, CRC-4 and opcode, and either presents B/A/op to the ALU core
// with a one-cycle pkt_valid pulse or raises a one-hot error report.

module mtm_alu_serial_rx #(
  parameter int unsigned DATA_BYTES = 8,
  parameter bit          CRC_CHECK  = 1'b1,
  parameter bit          OP_CHECK   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sin,
  output logic        pkt_valid,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        err_valid,
  output logic [2:0]  err_flags,
  output logic        busy
);

  localparam int unsigned CNT_W     = $clog2(DATA_BYTES + 1);
  localparam int unsigned BUF_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    DATA,
    STOP,
    RESYNC
  } state_t;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic             is_ctl;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] byte_cnt;
  logic             ovf;
  logic             resync_seen;
  logic [7:0]       byte_buf [BUF_BYTES];

  logic [31:0]      b_word;
  logic [31:0]      a_word;
  logic [2:0]       ctl_op;
  logic [3:0]       ctl_crc;
  logic [3:0]       exp_crc;
  logic             count_ok;
  logic             crc_ok;
  logic             op_ok;

  // CRC-4, polynomial x^4+x+1, init 0, message fed MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb = c[3] ^ msg[67 - i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return c;
  endfunction

  assign b_word = {byte_buf[0], byte_buf[1], byte_buf[2], byte_buf[3]};
  assign a_word = {byte_buf[4], byte_buf[5], byte_buf[6], byte_buf[7]};

  // Decode and validate the CTL byte currently held in the shift register.
  always_comb begin
    ctl_op   = shreg[6:4];
    ctl_crc  = shreg[3:0];
    exp_crc  = crc4({b_word, a_word, 1'b1, ctl_op});
    count_ok = (byte_cnt == CNT_W'(DATA_BYTES)) && !ovf;
    crc_ok   = !CRC_CHECK || (ctl_crc == exp_crc);
    op_ok    = !OP_CHECK || (ctl_op inside {3'b000, 3'b001, 3'b100, 3'b101});
  end

  // Bit-level deframing FSM plus packet assembly and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      is_ctl      <= 1'b0;
      shreg       <= '0;
      byte_cnt    <= '0;
      ovf         <= 1'b0;
      resync_seen <= 1'b0;
      for (int unsigned i = 0; i < BUF_BYTES; i++) byte_buf[i] <= '0;
      pkt_valid   <= 1'b0;
      a           <= '0;
      b           <= '0;
      op          <= '0;
      err_valid   <= 1'b0;
      err_flags   <= '0;
      busy        <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!sin) begin
            state <= TYPE;
            busy  <= 1'b1;
          end
        end
        TYPE: begin
          is_ctl  <= sin;
          bit_cnt <= 3'd7;
          state   <= DATA;
        end
        DATA: begin
          shreg <= {shreg[6:0], sin};
          if (bit_cnt == 3'd0) state <= STOP;
          else bit_cnt <= bit_cnt - 3'd1;
        end
        STOP: begin
          if (sin) begin
            state <= IDLE;
            if (!is_ctl) begin
              if (byte_cnt < CNT_W'(DATA_BYTES)) begin
                for (int unsigned i = 0; i < BUF_BYTES; i++)
                  if (i < DATA_BYTES && byte_cnt == CNT_W'(i)) byte_buf[i] <= shreg;
                byte_cnt <= byte_cnt + CNT_W'(1);
              end else begin
                ovf <= 1'b1;
              end
            end else begin
              busy     <= 1'b0;
              byte_cnt <= '0;
              ovf      <= 1'b0;
              if (!count_ok) begin
                err_valid <= 1'b1;
                err_flags <= 3'b100;
              end else if (!crc_ok) begin
                err_valid <= 1'b1;
                err_flags <= 3'b010;
              end else if (!op_ok) begin
                err_valid <= 1'b1;
                err_flags <= 3'b001;
              end else begin
                pkt_valid <= 1'b1;
                a         <= a_word;
                b         <= b_word;
                op        <= ctl_op;
              end
            end
          end else begin
            state       <= RESYNC;
            resync_seen <= 1'b0;
            err_valid   <= 1'b1;
            err_flags   <= 3'b100;
            busy        <= 1'b0;
            byte_cnt    <= '0;
            ovf         <= 1'b0;
          end
        end
        RESYNC: begin
          if (sin) begin
            resync_seen <= 1'b1;
            if (resync_seen) state <= IDLE;
          end else begin
            resync_seen <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
